pipeline_hazard_controller: RTL

- Central stall/flush sequencer for the 5-stage pipeline. Drives write-enables and flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazard classes:
  - load-use data hazards, detected in ID;
  - taken branches, resolved in MEM from the EX/MEM Branch and Zero fields;
  - multi-cycle data-memory accesses, which freeze the whole pipeline for a fixed wait count.
- Also keeps saturating stall and flush performance counters.

---
 rtl/pipeline_hazard_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and whole-pipeline freezes for multi-cycle data-memory accesses.
module pipeline_hazard_controller #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_mem_read,
    input  logic             exmem_mem_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             ex_mem_flush,
    output logic             mem_wb_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    localparam bit         HAS_WAIT  = (MEM_WAIT != 0);
    localparam logic [3:0] WAIT_INIT = 4'(HAS_WAIT ? MEM_WAIT - 1 : 0);

    state_t     state, state_nxt;
    logic [3:0] wcnt, wcnt_nxt;

    logic mem_acc, load_use, taken;
    logic freeze, eval_hz, taken_cyc;

    assign mem_acc  = (exmem_mem_read | exmem_mem_write) & HAS_WAIT;
    assign load_use = idex_mem_read & (idex_rt != 5'd0) &
                      ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt)));
    assign taken    = exmem_branch & exmem_zero;

    // Decide which regime this cycle is in; outputs are derived below.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        freeze    = 1'b0;
        eval_hz   = 1'b0;
        unique case (state)
            S_RUN: begin
                if (mem_acc) begin
                    freeze    = 1'b1;
                    state_nxt = S_WAIT;
                    wcnt_nxt  = WAIT_INIT;
                end else begin
                    eval_hz = 1'b1;
                end
            end
            S_WAIT: begin
                if (wcnt != 4'd0) begin
                    freeze   = 1'b1;
                    wcnt_nxt = wcnt - 4'd1;
                end else begin
                    // Release cycle: mem_acc is deliberately not looked at here
                    eval_hz   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_RUN;
                wcnt_nxt  = 4'd0;
            end
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_bubble = 1'b0;
        busy          = 1'b0;
        taken_cyc     = 1'b0;
        if (!rst) begin
            busy = (state == S_WAIT);
            if (freeze) begin
                mem_wb_bubble = 1'b1;
            end else begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
                if (eval_hz && taken) begin
                    // The load-use victim is in IF/ID and gets flushed anyway
                    pc_src       = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    taken_cyc    = 1'b1;
                end else if (eval_hz && load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (taken_cyc && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule
